mem_stage_wb_reg: RTL and testbench
===================================

// Module: mem_stage_wb_reg
// PURPOSE
//  MEM stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
//  - Consumes the PR3_* bundle and runs a req/ack handshake to a variable-latency data memory.
//  - Freezes upstream stages with stall while an access is outstanding.
//  - Registers the write-back bundle (PR4_*) for the WB stage.
// PARAMETERS
//  WORD_LEN     16  data/address width
//  INSTR_LEN    19  instruction width carried down the pipe
//  TIMEOUT      15  max BUSY cycles waiting for ack (used only with MEM_TIMEOUT_EN); must be >=1
// PORTS
//  clk                       in   1          clock, rising edge
//  rst                       in   1          reset, asynchronous, active-low
//  PR3_alu_out               in   WORD_LEN   ALU result, also memory address
//  PR3_RF_out2               in   WORD_LEN   store data
//  PR3_instruction           in   INSTR_LEN  instruction in MEM
//  PR3_MEM_read              in   1          load
//  PR3_MEM_write             in   1          store
//  PR3_sel_RF_write_src_MEM  in   1          1: write-back from memory, 0: from ALU
//  PR3_RF_write_en           in   1          instruction writes RF
//  dmem_req                  out  1          memory request, registered
//  dmem_we                   out  1          1 = write, registered
//  dmem_addr                 out  WORD_LEN   latched address
//  dmem_wdata                out  WORD_LEN   latched store data
//  dmem_rdata                in   WORD_LEN   read data, valid in ack cycle
//  dmem_ack                  in   1          access complete (one-cycle pulse)
//  stall                     out  1          combinational; 1 = hold IF..EX/MEM registers
//  PR4_wb_data               out  WORD_LEN   selected write-back value
//  PR4_instruction           out  INSTR_LEN  instruction in WB
//  PR4_RF_write_en           out  1          write-back enable
//  mem_err                   out  1          sticky timeout flag (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; dmem_req/dmem_we/addr/wdata=0; PR4_*=0; mem_err=0;
//    wait counter=0. Reset mid-access abandons the access; no PR4 update.
//  - access = PR3_MEM_read | PR3_MEM_write. Both set: store wins and read is ignored.
//  - FSM has 2 states:
//    IDLE, access=0: stall=0; PR4 loads from PR3 every edge.
//      PR4_wb_data=PR3_alu_out; PR4_RF_write_en=PR3_RF_write_en. Latency 1 cycle.
//    IDLE, access=1: stall=1; PR4 loads a bubble (instruction=0, RF_write_en=0).
//      Edge actions: latch addr=PR3_alu_out, wdata=PR3_RF_out2, we=PR3_MEM_write; dmem_req<=1; go BUSY.
//    BUSY, ack=0: stall=1; req and addr/wdata/we held stable; PR4 loads a bubble; counter++.
//    BUSY, ack=1: stall=0. Edge actions: dmem_req<=0; go IDLE; counter<=0.
//      PR4_instruction<=PR3_instruction; PR4_RF_write_en<=PR3_RF_write_en.
//      PR4_wb_data<=(sel_MEM & load) ? dmem_rdata : PR3_alu_out.
//  - Memory access latency = 2 + N cycles, where N = cycles before ack.
//  - Upstream advances on the ack edge, so back-to-back accesses get no duplicate write-back.
//  - dmem_ack is ignored in IDLE. dmem_rdata is sampled only in the BUSY ack cycle.
//  - Store: write-back data is PR3_alu_out; RF_write_en passes through unchanged.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - In BUSY, ack=0 with counter==TIMEOUT-1: the access aborts.
//    - Abort cycle: stall=0. Edge actions: dmem_req<=0; go IDLE; mem_err<=1 (sticky until reset);
//      PR4 loads PR3_instruction with RF_write_en=0.
//    - ack and timeout in the same cycle: ack wins.
//  MEM_TIMEOUT_EN undefined: no counter; waits for ack indefinitely; mem_err tied 0.
// TESTING
//  1. ALU op, alu_out=0x1234, RF_write_en=1, no access
//     -> next edge PR4_wb_data=0x1234, PR4_RF_write_en=1; stall=0 throughout.
//  2. Load addr 0x0040, memory acks 3 cycles after req, rdata=0xBEEF
//     -> stall=1 for 4 cycles; PR4_wb_data=0xBEEF on the ack edge; bubbles before it.
//  3. Store addr 0x0010, RF_out2=0x00AA, immediate ack
//     -> dmem_we=1, addr=0x0010, wdata=0x00AA held while req=1; req drops after ack edge.
//  4. Back-to-back loads 0x0002, 0x0004, each acked after 1 cycle
//     -> exactly two write-backs, in order, with no duplicates.
//  5. rst=0 asserted mid-BUSY
//     -> dmem_req=0, stall=0, PR4_*=0 immediately; after release, next access proceeds normally.
//  6. MEM_TIMEOUT_EN, TIMEOUT=15, no ack
//     -> abort after 15 BUSY cycles; mem_err=1; PR4_RF_write_en=0; mem_err stays 1 until reset.

Source files
------------

// File: rtl/mem_stage_wb_reg_if.sv
// Data-memory bus between the MEM stage and a variable-latency data memory.
//   master (MEM stage): drives dmem_req/dmem_we/dmem_addr/dmem_wdata,
//                       receives dmem_rdata/dmem_ack.
//   slave  (memory)   : the mirror image.
interface mem_stage_wb_reg_if #(
  parameter int WORD_LEN = 16
);
  logic                dmem_req;
  logic                dmem_we;
  logic [WORD_LEN-1:0] dmem_addr;
  logic [WORD_LEN-1:0] dmem_wdata;
  logic [WORD_LEN-1:0] dmem_rdata;
  logic                dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_wb_reg.sv
// MEM stage plus MEM/WB pipeline register.
// Takes the PR3_* bundle from EX/MEM, runs a req/ack access to the data memory
// (dmem bus interface), stalls upstream while an access is outstanding and
// registers the write-back bundle PR4_* for the WB stage.
// Ports:
//   clk, rst (async, active-low)
//   PR3_*    : EX/MEM bundle in
//   dmem     : data-memory bus (master side)
//   stall    : combinational hold for IF..EX/MEM registers
//   PR4_*    : MEM/WB bundle out
//   mem_err  : sticky access-timeout flag
// Optional feature macro: MEM_TIMEOUT_EN -- abort an access after TIMEOUT BUSY
// cycles without ack and set mem_err. Undefined: wait for ack indefinitely.
module mem_stage_wb_reg #(
  parameter int WORD_LEN  = 16,
  parameter int INSTR_LEN = 19,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_LEN-1:0]  PR3_alu_out,
  input  logic [WORD_LEN-1:0]  PR3_RF_out2,
  input  logic [INSTR_LEN-1:0] PR3_instruction,
  input  logic                 PR3_MEM_read,
  input  logic                 PR3_MEM_write,
  input  logic                 PR3_sel_RF_write_src_MEM,
  input  logic                 PR3_RF_write_en,
  mem_stage_wb_reg_if.master   dmem,
  output logic                 stall,
  output logic [WORD_LEN-1:0]  PR4_wb_data,
  output logic [INSTR_LEN-1:0] PR4_instruction,
  output logic                 PR4_RF_write_en,
  output logic                 mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [WORD_LEN-1:0]   addr_q, addr_d;
  logic [WORD_LEN-1:0]   wdata_q, wdata_d;
  logic [WORD_LEN-1:0]   wb_q, wb_d;
  logic [INSTR_LEN-1:0]  ins_q, ins_d;
  logic                  rfwe_q, rfwe_d;
  logic                  stall_c;
  logic                  access;
  logic                  is_load;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign access  = PR3_MEM_read | PR3_MEM_write;
  // Store wins when both read and write are set.
  assign is_load = PR3_MEM_read & ~PR3_MEM_write;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wb_d    = '0;
    ins_d   = '0;
    rfwe_d  = 1'b0;
    stall_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          addr_d  = PR3_alu_out;
          wdata_d = PR3_RF_out2;
          we_d    = PR3_MEM_write;
          req_d   = 1'b1;
          state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          wb_d   = PR3_alu_out;
          ins_d  = PR3_instruction;
          rfwe_d = PR3_RF_write_en;
        end
      end
      BUSY: begin
        // PR3 is held by stall, so its fields are still those of the access.
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          ins_d   = PR3_instruction;
          rfwe_d  = PR3_RF_write_en;
          wb_d    = (PR3_sel_RF_write_src_MEM & is_load) ? dmem.dmem_rdata : PR3_alu_out;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          ins_d   = PR3_instruction;
          wb_d    = PR3_alu_out;
          rfwe_d  = 1'b0;
        end
`endif
        else begin
          stall_c = 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
      ins_q   <= '0;
      rfwe_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      ins_q   <= ins_d;
      rfwe_q  <= rfwe_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Stall is forced low while reset is asserted, even if PR3 requests access.
  assign stall           = stall_c & rst;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign PR4_wb_data     = wb_q;
  assign PR4_instruction = ins_q;
  assign PR4_RF_write_en = rfwe_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_err = err_q;
`else
  // Without the timeout there is no error source; only an illegal TIMEOUT
  // setting (< 1) would show here.
  assign mem_err = (TIMEOUT < 1);
`endif

endmodule

// File: tb/tb_mem_stage_wb_reg.sv
module tb_mem_stage_wb_reg;
  localparam int WL = 16;
  localparam int IL = 19;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] alu, rf2;
  logic [IL-1:0] ins;
  logic          mrd, mwr, sel, rfwe;
  logic          stall, pr4_we, mem_err;
  logic [WL-1:0] pr4_wb;
  logic [IL-1:0] pr4_ins;

  int total = 0;
  int bad   = 0;
  logic          exp_err = 1'b0;
  logic [WL-1:0] mem [0:255];

  mem_stage_wb_reg_if #(.WORD_LEN(WL)) dmem_if ();

  mem_stage_wb_reg #(.WORD_LEN(WL), .INSTR_LEN(IL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .PR3_alu_out(alu), .PR3_RF_out2(rf2), .PR3_instruction(ins),
    .PR3_MEM_read(mrd), .PR3_MEM_write(mwr),
    .PR3_sel_RF_write_src_MEM(sel), .PR3_RF_write_en(rfwe),
    .dmem(dmem_if.master), .stall(stall),
    .PR4_wb_data(pr4_wb), .PR4_instruction(pr4_ins), .PR4_RF_write_en(pr4_we),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [WL-1:0] a, input logic [WL-1:0] d, input logic [IL-1:0] i,
                       input logic rd, input logic wr, input logic s, input logic we);
    alu = a; rf2 = d; ins = i; mrd = rd; mwr = wr; sel = s; rfwe = we;
  endtask

  // Non-memory instruction: one cycle, straight through to PR4.
  task automatic alu_op(input logic [WL-1:0] a, input logic [IL-1:0] i, input logic we);
    drive(a, 16'($urandom), i, 1'b0, 1'b0, 1'($urandom), we);
    dmem_if.dmem_ack   = 1'($urandom);   // must be ignored in IDLE
    dmem_if.dmem_rdata = 16'($urandom);
    #1;
    chk("alu_stall", stall, 0);
    chk("alu_req", dmem_if.dmem_req, 0);
    @(posedge clk); #1;
    dmem_if.dmem_ack = 1'b0;
    chk("alu_wb", pr4_wb, a);
    chk("alu_ins", pr4_ins, i);
    chk("alu_we", pr4_we, we);
    chk("alu_err", mem_err, exp_err);
  endtask

  // Memory instruction acked after n BUSY cycles without ack.
  task automatic mem_op(input logic [WL-1:0] a, input logic [WL-1:0] d, input logic [IL-1:0] i,
                        input logic rd, input logic wr, input logic s, input logic we, input int n);
    int stalls = 0;
    logic ld;
    logic [WL-1:0] exp_wb;
    ld = rd & ~wr;
    drive(a, d, i, rd, wr, s, we);
    dmem_if.dmem_ack = 1'($urandom);
    #1;
    chk("acc_stall0", stall, 1);
    chk("acc_req0", dmem_if.dmem_req, 0);
    stalls++;
    @(posedge clk); #1;
    chk("acc_req1", dmem_if.dmem_req, 1);
    chk("acc_we", dmem_if.dmem_we, wr);
    chk("acc_addr", dmem_if.dmem_addr, a);
    chk("acc_wdata", dmem_if.dmem_wdata, d);
    chk("bub_ins", pr4_ins, 0);
    chk("bub_we", pr4_we, 0);
    for (int k = 0; k < n; k++) begin
      dmem_if.dmem_ack   = 1'b0;
      dmem_if.dmem_rdata = 16'($urandom);
      #1;
      chk("wait_stall", stall, 1);
      stalls++;
      @(posedge clk); #1;
      chk("wait_req", dmem_if.dmem_req, 1);
      chk("wait_addr", dmem_if.dmem_addr, a);
      chk("wait_wdata", dmem_if.dmem_wdata, d);
      chk("wait_bub", {pr4_we, pr4_ins}, 0);
      chk("wait_err", mem_err, exp_err);
    end
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = ld ? mem[a[7:0]] : 16'($urandom);
    exp_wb = (s & ld) ? mem[a[7:0]] : a;
    #1;
    chk("ack_stall", stall, 0);
    @(posedge clk); #1;
    dmem_if.dmem_ack = 1'b0;
    if (wr) mem[a[7:0]] = d;
    chk("ack_req", dmem_if.dmem_req, 0);
    chk("stall_cycles", stalls, n + 1);
    chk("ack_wb", pr4_wb, exp_wb);
    chk("ack_ins", pr4_ins, i);
    chk("ack_we", pr4_we, we);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    mem[8'h40] = 16'hBEEF;
    rst = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
    #2;
    chk("rst_req", dmem_if.dmem_req, 0);
    chk("rst_pr4", {pr4_we, pr4_ins, pr4_wb}, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_addr", {dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed steps
    alu_op(16'h1234, 19'h00123, 1'b1);
    mem_op(16'h0040, 16'h0000, 19'h00A01, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    chk("load_beef", pr4_wb, 16'hBEEF);
    mem_op(16'h0010, 16'h00AA, 19'h00B02, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    mem_op(16'h0002, 16'h0000, 19'h00C03, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    mem_op(16'h0004, 16'h0000, 19'h00C04, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    alu_op(16'h5555, 19'h00D05, 1'b1);
    // Read+write together: store wins
    mem_op(16'h0010, 16'h1357, 19'h00E06, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    mem_op(16'h0010, 16'h0000, 19'h00E07, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    chk("store_then_load", pr4_wb, 16'h1357);

    // Reset in the middle of an access
    drive(16'h0030, 16'h0000, 19'h00F08, 1'b1, 1'b0, 1'b1, 1'b1);
    #1; @(posedge clk); #1;
    dmem_if.dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst_req", dmem_if.dmem_req, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_pr4", {pr4_we, pr4_ins, pr4_wb}, 0);
    chk("mrst_err", mem_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_op(16'h0030, 16'h0000, 19'h00F09, 1'b1, 1'b0, 1'b1, 1'b1, 2);

    // Long wait without ack
`ifdef MEM_TIMEOUT_EN
    drive(16'h0044, 16'h0000, 19'h01111, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_if.dmem_ack = 1'b0;
    #1; @(posedge clk); #1;
    for (int k = 0; k < TO - 1; k++) begin
      chk("to_stall", stall, 1);
      @(posedge clk); #1;
    end
    chk("to_abort_stall", stall, 0);
    @(posedge clk); #1;
    exp_err = 1'b1;
    chk("to_req", dmem_if.dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_ins", pr4_ins, 19'h01111);
    chk("to_we", pr4_we, 0);
    alu_op(16'h0101, 19'h01112, 1'b1);
    mem_op(16'h0006, 16'h0000, 19'h01113, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    chk("to_err_sticky", mem_err, 1);
`else
    mem_op(16'h0044, 16'h0000, 19'h01111, 1'b1, 1'b0, 1'b1, 1'b1, 20);
    chk("noto_err", mem_err, 0);
`endif

    // Random traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      logic [WL-1:0] a, d;
      logic [IL-1:0] i;
      int kind;
      a = 16'(($urandom % 16) * 2);
      d = 16'($urandom);
      i = 19'($urandom) | 19'h1;
      kind = int'($urandom % 4);
      if (kind == 0)
        alu_op(16'($urandom), i, 1'($urandom));
      else
        mem_op(a, d, i, kind != 2, kind >= 2, 1'($urandom), 1'($urandom), int'($urandom % 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
